// File: rtl/irrigation_tick_gen.sv
// irrigation_tick_gen
// Timebase and valve duty controller for the irrigation controller.
// A single free-running prescaler produces single-cycle clock enables for
// the matrix scan, display refresh and slow valve timing, plus a 50% square
// wave for the display. A three-state FSM (IDLE / ON / OFF) switches the
// valve according to the selected watering mode. Each mode has its own
// ON/OFF lengths, counted in tick_slow events.
//
// Ports
//   clk           system clock; all state is on its rising edge
//   reset         asynchronous, active-high reset
//   en            1 = prescaler counts; 0 = prescaler holds and all tick_* are 0
//   gotejamento   drip mode request (asynchronous switch)
//   aspersao      sprinkler mode request (asynchronous switch, wins over drip)
//   tick_matrix   1-cycle enable, period 2^(MATRIX_BIT+1)
//   tick_display  1-cycle enable, period 2^(DISPLAY_BIT+1)
//   tick_slow     1-cycle enable, period 2^(SLOW_BIT+1), valve time unit
//   sq_display    square wave, cnt[DISPLAY_BIT]
//   valve_en      1 while the FSM is in ON
//   mode_out      active mode: 00 none, 01 drip, 10 sprinkler
module irrigation_tick_gen #(
  parameter int CNT_W       = 24,
  parameter int MATRIX_BIT  = 14,
  parameter int DISPLAY_BIT = 16,
  parameter int SLOW_BIT    = 23,
  parameter int PH_W        = 8,
  parameter int ON_DRIP     = 1,
  parameter int OFF_DRIP    = 2,
  parameter int ON_ASP      = 2,
  parameter int OFF_ASP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       gotejamento,
  input  logic       aspersao,
  output logic       tick_matrix,
  output logic       tick_display,
  output logic       tick_slow,
  output logic       sq_display,
  output logic       valve_en,
  output logic [1:0] mode_out
);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_DRIP = 2'b01;
  localparam logic [1:0] MODE_ASP  = 2'b10;

  // Phase counters load "length - 1" so that a phase spans exactly
  // "length" tick_slow events.
  localparam logic [PH_W-1:0] ON_DRIP_M1  = PH_W'(ON_DRIP - 1);
  localparam logic [PH_W-1:0] OFF_DRIP_M1 = PH_W'(OFF_DRIP - 1);
  localparam logic [PH_W-1:0] ON_ASP_M1   = PH_W'(ON_ASP - 1);
  localparam logic [PH_W-1:0] OFF_ASP_M1  = PH_W'(OFF_ASP - 1);
  localparam logic            OFF_DRIP_Z  = (OFF_DRIP == 0);
  localparam logic            OFF_ASP_Z   = (OFF_ASP == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_OFF  = 2'b10
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic             gote_meta, gote_sync;
  logic             asp_meta, asp_sync;
  logic [1:0]       mode_req;
  logic [PH_W-1:0]  on_m1, off_m1;
  logic             off_zero;

  state_t           state, state_n;
  logic [PH_W-1:0]  phase, phase_n;
  logic [1:0]       mode_q, mode_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A tick fires when the low bits of the prescaler are all ones.
  // This gives exactly one pulse per 2^(BIT+1) cycles.
  assign tick_matrix  = en & (&cnt[MATRIX_BIT:0]);
  assign tick_display = en & (&cnt[DISPLAY_BIT:0]);
  assign tick_slow    = en & (&cnt[SLOW_BIT:0]);
  assign sq_display   = cnt[DISPLAY_BIT];

  // The mode switches are asynchronous. Each one passes through two flops
  // before the FSM sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gote_meta <= 1'b0;
      gote_sync <= 1'b0;
      asp_meta  <= 1'b0;
      asp_sync  <= 1'b0;
    end else begin
      gote_meta <= gotejamento;
      gote_sync <= gote_meta;
      asp_meta  <= aspersao;
      asp_sync  <= asp_meta;
    end
  end

  // The requested mode and its phase lengths. Sprinkler has priority.
  always_comb begin
    mode_req = MODE_NONE;
    on_m1    = ON_DRIP_M1;
    off_m1   = OFF_DRIP_M1;
    off_zero = OFF_DRIP_Z;
    if (asp_sync) begin
      mode_req = MODE_ASP;
      on_m1    = ON_ASP_M1;
      off_m1   = OFF_ASP_M1;
      off_zero = OFF_ASP_Z;
    end else if (gote_sync) begin
      mode_req = MODE_DRIP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      phase  <= '0;
      mode_q <= MODE_NONE;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      mode_q <= mode_n;
    end
  end

  // Removing or changing the mode takes priority over a tick_slow on the
  // same cycle. A zero OFF length keeps the valve ON by reloading the ON
  // phase instead of entering OFF.
  always_comb begin
    state_n = state;
    phase_n = phase;
    mode_n  = mode_q;
    case (state)
      S_IDLE: begin
        if (mode_req != MODE_NONE) begin
          state_n = S_ON;
          phase_n = on_m1;
          mode_n  = mode_req;
        end
      end
      S_ON, S_OFF: begin
        if (mode_req == MODE_NONE) begin
          state_n = S_IDLE;
          phase_n = '0;
          mode_n  = MODE_NONE;
        end else if (mode_req != mode_q) begin
          state_n = S_ON;
          phase_n = on_m1;
          mode_n  = mode_req;
        end else if (tick_slow) begin
          if (phase != '0) begin
            phase_n = phase - 1'b1;
          end else if ((state == S_OFF) || off_zero) begin
            state_n = S_ON;
            phase_n = on_m1;
          end else begin
            state_n = S_OFF;
            phase_n = off_m1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        phase_n = '0;
        mode_n  = MODE_NONE;
      end
    endcase
  end

  assign valve_en = (state == S_ON);
  assign mode_out = mode_q;

endmodule
